// File: rtl/serializer_pw.sv
// Parallel-to-serial converter with per-word bit count, valid/ready on both sides,
// selectable bit order and back-to-back word streaming.
module serializer_pw #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CNT_W     = $clog2(DATA_W + 1),
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CNT_W-1:0]  data_len_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic              ser_data_o,
    output logic              ser_val_o,
    input  logic              ser_rdy_i,
    output logic              busy_o
);

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] sreg_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              last_c;
    logic              accept_c;
    logic              load_c;
    logic [CNT_W-1:0]  len_eff_c;
    logic [DATA_W-1:0] len_mask_c;
    logic [DATA_W-1:0] load_val_c;
    logic [DATA_W-1:0] shift_val_c;

    // Clamp the length and align the word so its first bit sits on the output tap
    always_comb begin
        len_eff_c   = (data_len_i > LEN_MAX) ? LEN_MAX : data_len_i;
        len_mask_c  = ~({DATA_W{1'b1}} << len_eff_c);
        load_val_c  = data_i & len_mask_c;
        shift_val_c = {1'b0, sreg_q[DATA_W-1:1]};
        if (MSB_FIRST) begin
            load_val_c  = data_i << (LEN_MAX - len_eff_c);
            shift_val_c = {sreg_q[DATA_W-2:0], 1'b0};
        end
    end

    // Handshake: a new word is taken when idle or on the edge that consumes the last bit
    always_comb begin
        last_c     = (state_q == SHIFT) && (cnt_q == CNT_ONE) && ser_rdy_i;
        data_rdy_o = rst_ni && ((state_q == IDLE) || last_c);
        accept_c   = data_val_i && data_rdy_o;
        load_c     = accept_c && (len_eff_c != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else if (state_q == IDLE) begin
            if (load_c) begin
                sreg_q  <= load_val_c;
                cnt_q   <= len_eff_c;
                state_q <= SHIFT;
            end
        end else if (ser_rdy_i) begin
            if (cnt_q > CNT_ONE) begin
                sreg_q <= shift_val_c;
                cnt_q  <= cnt_q - CNT_ONE;
            end else if (load_c) begin
                sreg_q <= load_val_c;
                cnt_q  <= len_eff_c;
            end else begin
                sreg_q  <= '0;
                cnt_q   <= '0;
                state_q <= IDLE;
            end
        end
    end

    // Register is cleared whenever idle, so the tap reads 0 without a valid bit
    assign ser_data_o = MSB_FIRST ? sreg_q[DATA_W-1] : sreg_q[0];
    assign ser_val_o  = (state_q == SHIFT);
    assign busy_o     = (state_q == SHIFT);

endmodule
